// File: rtl/uart_fifo_periph.sv
// Memory-mapped UART front end: TX/RX byte FIFOs, status/control registers and loopback,
// sequencing the UART core's tx_start/tx_busy and rx_ready/rx_clear handshakes.
//
// TX FSM  state     | meaning
//         TX_IDLE   | pop head when FIFO non-empty and UART not busy (loopback: pop into RX)
//         TX_LAUNCH | popped byte held on uart_tx_data; start pulse registered out next edge
//         TX_ACK    | wait for busy, give up after 4 cycles and treat byte as sent
//         TX_DONE   | wait for busy to drop
// RX FSM  RX_IDLE   | capture on uart_rx_ready (frozen while loopback)
//         RX_WAIT   | wait for uart_rx_ready low, one capture per byte
module uart_fifo_periph #(
  parameter int DATA_WIDTH = 32,
  parameter int TX_DEPTH   = 8,
  parameter int RX_DEPTH   = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sel,
  input  logic                  we,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  uart_tx_start,
  output logic [7:0]            uart_tx_data,
  input  logic                  uart_tx_busy,
  input  logic [7:0]            uart_rx_data,
  input  logic                  uart_rx_ready,
  output logic                  uart_rx_clear,
  output logic                  irq
);

  localparam int TPW = $clog2(TX_DEPTH);
  localparam int TCW = TPW + 1;
  localparam int RPW = $clog2(RX_DEPTH);
  localparam int RCW = RPW + 1;
  localparam int IW  = ADDR_WIDTH - 2;
  localparam logic [TCW-1:0] TX_FULL_CNT = TCW'(TX_DEPTH);
  localparam logic [RCW-1:0] RX_FULL_CNT = RCW'(RX_DEPTH);
  localparam logic [IW-1:0]  A_TX = IW'(0);
  localparam logic [IW-1:0]  A_RX = IW'(1);
  localparam logic [IW-1:0]  A_ST = IW'(2);
  localparam logic [IW-1:0]  A_CT = IW'(3);

  typedef enum logic [1:0] {TX_IDLE, TX_LAUNCH, TX_ACK, TX_DONE} tx_state_e;
  typedef enum logic {RX_IDLE, RX_WAIT} rx_state_e;

  tx_state_e        tx_state_q, tx_state_d;
  rx_state_e        rx_state_q, rx_state_d;
  logic [TPW-1:0]   tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TCW-1:0]   tx_count_q, tx_count_d;
  logic [RPW-1:0]   rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RCW-1:0]   rx_count_q, rx_count_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_start_q, tx_start_d;
  logic             rx_clear_q, rx_clear_d;
  logic [1:0]       ack_cnt_q, ack_cnt_d;
  logic             rx_overrun_q, rx_overrun_d;
  logic             tx_overflow_q, tx_overflow_d;
  logic             loopback_q, loopback_d;
  logic             irq_q, irq_d;
  logic [7:0]       tx_mem_q [TX_DEPTH];
  logic [7:0]       rx_mem_q [RX_DEPTH];

  logic [IW-1:0] reg_idx;
  logic wr_tx, rd_rx, wr_ctrl, flush_rx, flush_tx, clr_sticky;
  logic tx_empty, tx_full, rx_empty, rx_full;
  logic tx_pop, tx_push, rx_cap, rx_push_req, rx_push, rx_pop;
  logic [7:0] tx_head, rx_head, rx_push_byte;
  logic unused_bits;

  assign reg_idx    = addr[ADDR_WIDTH-1:2];
  assign wr_tx      = sel & we & (reg_idx == A_TX);
  assign rd_rx      = sel & re & (reg_idx == A_RX);
  assign wr_ctrl    = sel & we & (reg_idx == A_CT);
  assign flush_rx   = wr_ctrl & wdata[0];
  assign flush_tx   = wr_ctrl & wdata[1];
  assign clr_sticky = wr_ctrl & wdata[2];
  assign unused_bits = ^{addr[1:0], wdata[DATA_WIDTH-1:8]};

  assign tx_empty = (tx_count_q == '0);
  assign tx_full  = (tx_count_q == TX_FULL_CNT);
  assign rx_empty = (rx_count_q == '0);
  assign rx_full  = (rx_count_q == RX_FULL_CNT);
  assign tx_head  = tx_mem_q[tx_rd_ptr_q];
  assign rx_head  = rx_mem_q[rx_rd_ptr_q];

  // A push into a full FIFO is accepted only when a pop frees the slot in the same cycle.
  assign tx_pop       = (tx_state_q == TX_IDLE) & ~tx_empty & ~uart_tx_busy;
  assign tx_push      = wr_tx & (~tx_full | tx_pop);
  assign rx_cap       = (rx_state_q == RX_IDLE) & uart_rx_ready & ~loopback_q;
  assign rx_push_req  = rx_cap | (tx_pop & loopback_q);
  assign rx_push_byte = loopback_q ? tx_head : uart_rx_data;
  assign rx_pop       = rd_rx & ~rx_empty;
  assign rx_push      = rx_push_req & (~rx_full | rx_pop);

  always_comb begin
    tx_wr_ptr_d = tx_wr_ptr_q;
    tx_rd_ptr_d = tx_rd_ptr_q;
    tx_count_d  = tx_count_q;
    rx_wr_ptr_d = rx_wr_ptr_q;
    rx_rd_ptr_d = rx_rd_ptr_q;
    rx_count_d  = rx_count_q;
    if (flush_tx) begin
      tx_wr_ptr_d = '0;
      tx_rd_ptr_d = '0;
      tx_count_d  = '0;
    end else begin
      if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + TPW'(1);
      if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + TPW'(1);
      tx_count_d = tx_count_q + TCW'(tx_push) - TCW'(tx_pop);
    end
    if (flush_rx) begin
      rx_wr_ptr_d = '0;
      rx_rd_ptr_d = '0;
      rx_count_d  = '0;
    end else begin
      if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + RPW'(1);
      if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + RPW'(1);
      rx_count_d = rx_count_q + RCW'(rx_push) - RCW'(rx_pop);
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    ack_cnt_d  = ack_cnt_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (tx_pop && !loopback_q) begin
          tx_data_d  = tx_head;
          tx_state_d = TX_LAUNCH;
        end
      end
      TX_LAUNCH: begin
        tx_start_d = 1'b1;
        ack_cnt_d  = 2'd3;
        tx_state_d = TX_ACK;
      end
      TX_ACK: begin
        if (uart_tx_busy)          tx_state_d = TX_DONE;
        else if (ack_cnt_q == '0)  tx_state_d = TX_IDLE;
        else                       ack_cnt_d  = ack_cnt_q - 2'd1;
      end
      TX_DONE: begin
        if (!uart_tx_busy) tx_state_d = TX_IDLE;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_clear_d = 1'b0;
    unique case (rx_state_q)
      RX_IDLE: begin
        if (rx_cap) begin
          rx_clear_d = 1'b1;
          rx_state_d = RX_WAIT;
        end
      end
      RX_WAIT: begin
        if (!loopback_q && !uart_rx_ready) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_overrun_d  = (rx_overrun_q & ~clr_sticky) | (rx_push_req & ~rx_push);
    tx_overflow_d = (tx_overflow_q & ~clr_sticky) | (wr_tx & ~tx_push);
    loopback_d    = wr_ctrl ? wdata[3] : loopback_q;
    irq_d         = (rx_count_q != '0) | rx_overrun_q;
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      if (reg_idx == A_RX) begin
        if (!rx_empty) rdata[7:0] = rx_head;
      end else if (reg_idx == A_ST) begin
        rdata[0]     = ~rx_empty;
        rdata[1]     = tx_full;
        rdata[2]     = tx_empty;
        rdata[3]     = rx_overrun_q;
        rdata[4]     = tx_overflow_q;
        rdata[5]     = (tx_state_q == TX_IDLE) & tx_empty;
        rdata[6]     = loopback_q;
        rdata[15:8]  = 8'(rx_count_q);
        rdata[23:16] = 8'(tx_count_q);
      end else if (reg_idx == A_CT) begin
        rdata[3] = loopback_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_ptr_q] <= wdata[7:0];
    if (rx_push) rx_mem_q[rx_wr_ptr_q] <= rx_push_byte;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state_q    <= TX_IDLE;
      rx_state_q    <= RX_IDLE;
      tx_wr_ptr_q   <= '0;
      tx_rd_ptr_q   <= '0;
      tx_count_q    <= '0;
      rx_wr_ptr_q   <= '0;
      rx_rd_ptr_q   <= '0;
      rx_count_q    <= '0;
      tx_data_q     <= '0;
      tx_start_q    <= 1'b0;
      rx_clear_q    <= 1'b0;
      ack_cnt_q     <= '0;
      rx_overrun_q  <= 1'b0;
      tx_overflow_q <= 1'b0;
      loopback_q    <= 1'b0;
      irq_q         <= 1'b0;
    end else begin
      tx_state_q    <= tx_state_d;
      rx_state_q    <= rx_state_d;
      tx_wr_ptr_q   <= tx_wr_ptr_d;
      tx_rd_ptr_q   <= tx_rd_ptr_d;
      tx_count_q    <= tx_count_d;
      rx_wr_ptr_q   <= rx_wr_ptr_d;
      rx_rd_ptr_q   <= rx_rd_ptr_d;
      rx_count_q    <= rx_count_d;
      tx_data_q     <= tx_data_d;
      tx_start_q    <= tx_start_d;
      rx_clear_q    <= rx_clear_d;
      ack_cnt_q     <= ack_cnt_d;
      rx_overrun_q  <= rx_overrun_d;
      tx_overflow_q <= tx_overflow_d;
      loopback_q    <= loopback_d;
      irq_q         <= irq_d;
    end
  end

  assign uart_tx_start = tx_start_q;
  assign uart_tx_data  = tx_data_q;
  assign uart_rx_clear = rx_clear_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_uart_fifo_periph.sv
// Scoreboarded bench for uart_fifo_periph: queue-based TX/RX reference model, a UART
// busy model, and negedge monitors that check launched bytes and RXDATA pops.
module tb_uart_fifo_periph;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0, we = 1'b0, re = 1'b0;
  logic [3:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        uart_tx_start;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_busy;
  logic [7:0]  uart_rx_data = '0;
  logic        uart_rx_ready = 1'b0;
  logic        uart_rx_clear;
  logic        irq;

  logic busy_force = 1'b0, busy_en = 1'b1, model_busy = 1'b0;
  assign uart_tx_busy = busy_force | model_busy;

  uart_fifo_periph #(.DATA_WIDTH(32), .TX_DEPTH(8), .RX_DEPTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .sel(sel), .we(we), .re(re), .addr(addr),
    .wdata(wdata), .rdata(rdata), .uart_tx_start(uart_tx_start),
    .uart_tx_data(uart_tx_data), .uart_tx_busy(uart_tx_busy),
    .uart_rx_data(uart_rx_data), .uart_rx_ready(uart_rx_ready),
    .uart_rx_clear(uart_rx_clear), .irq(irq)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  int start_cnt = 0, first_start_cyc = 0, last_start_cyc = 0, prev_start_cyc = 0;
  int clr_cnt = 0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_model[$];
  logic       exp_ovr = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: launched bytes and RXDATA pops against the reference queues.
  initial forever begin
    logic [7:0] e;
    @(negedge clk);
    if (uart_tx_start) begin
      check("start_while_busy", {31'd0, uart_tx_busy}, 32'd0);
      if (tx_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_start: got data 0x%02h expected no start", uart_tx_data);
      end else begin
        e = tx_exp_q.pop_front();
        check("tx_data", {24'd0, uart_tx_data}, {24'd0, e});
      end
      if (start_cnt == 0) first_start_cyc = cyc;
      prev_start_cyc = last_start_cyc;
      last_start_cyc = cyc;
      start_cnt++;
    end
    if (uart_rx_clear) clr_cnt++;
    if (sel && re && addr[3:2] == 2'd1) begin
      e = (rx_model.size() != 0) ? rx_model.pop_front() : 8'h00;
      check("rxdata", rdata, {24'd0, e});
    end
  end

  // UART transmitter model: busy one cycle after start, held for 10 cycles.
  initial forever begin
    @(negedge clk);
    if (uart_tx_start && busy_en) begin
      @(posedge clk);
      #1 model_busy = 1'b1;
      repeat (10) @(posedge clk);
      #1 model_busy = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; re = 1'b0; addr = a; wdata = d;
    @(posedge clk); #1;
    sel = 1'b0; we = 1'b0; wdata = '0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    sel = 1'b1; we = 1'b0; re = 1'b0; addr = a;
    @(negedge clk);
    d = rdata;
    @(posedge clk); #1;
    sel = 1'b0;
  endtask

  task automatic rx_read();
    sel = 1'b1; re = 1'b1; addr = 4'h4;
    @(posedge clk); #1;
    sel = 1'b0; re = 1'b0;
  endtask

  task automatic tx_send(input logic [7:0] b);
    tx_exp_q.push_back(b);
    bus_write(4'h0, {24'd0, b});
  endtask

  task automatic model_capture(input logic [7:0] b);
    if (rx_model.size() < 8) rx_model.push_back(b);
    else exp_ovr = 1'b1;
  endtask

  task automatic drive_rx(input logic [7:0] b);
    uart_rx_ready = 1'b1; uart_rx_data = b;
    @(posedge clk); #1;
    check("rx_clear", {31'd0, uart_rx_clear}, 32'd1);
    model_capture(b);
    uart_rx_ready = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_tx_idle();
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < 400; i++) begin
      bus_read(4'h8, s);
      if (s[5]) break;
    end
    check("tx_idle", {31'd0, s[5]}, 32'd1);
  endtask

  initial begin
    logic [31:0] s;
    int c0, clr0, sc;
    logic [7:0] b;

    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    check("rst_tx_start", {31'd0, uart_tx_start}, 32'd0);
    check("rst_tx_data", {24'd0, uart_tx_data}, 32'd0);
    check("rst_rx_clear", {31'd0, uart_rx_clear}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    bus_read(4'h8, s);
    check("rst_status", s, 32'h0000_0024);

    // three bytes through the UART model
    tx_send(8'h41);
    c0 = cyc;
    tx_send(8'h42);
    tx_send(8'h43);
    wait_tx_idle();
    check("start_count3", start_cnt, 3);
    check("start_latency", first_start_cyc - c0, 2);

    // ACK timeout: UART never reports busy
    busy_en = 1'b0;
    tx_send(8'($urandom));
    tx_send(8'($urandom));
    wait_tx_idle();
    check("start_count5", start_cnt, 5);
    check("ack_timeout_spacing", last_start_cyc - prev_start_cyc, 6);
    busy_en = 1'b1;

    // RX overrun with nine bytes and no reads
    clr0 = clr_cnt;
    for (int i = 0; i < 9; i++) drive_rx(8'h10 + 8'(i));
    check("rx_clear_count", clr_cnt - clr0, 9);
    bus_read(4'h8, s);
    check("rx_count_full", {24'd0, s[15:8]}, 32'd8);
    check("rx_overrun_set", {31'd0, s[3]}, 32'd1);
    check("rx_not_empty", {31'd0, s[0]}, 32'd1);
    check("irq_set", {31'd0, irq}, 32'd1);
    for (int i = 0; i < 9; i++) rx_read();
    bus_write(4'hC, 32'h4);
    exp_ovr = 1'b0;
    bus_read(4'h8, s);
    check("rx_overrun_clr", {31'd0, s[3]}, 32'd0);
    check("rx_count_empty", {24'd0, s[15:8]}, 32'd0);
    check("irq_clr", {31'd0, irq}, 32'd0);

    // TX overflow while UART busy, then flush
    busy_force = 1'b1;
    for (int i = 0; i < 9; i++) bus_write(4'h0, $urandom & 32'hFF);
    bus_read(4'h8, s);
    check("tx_count_full", {24'd0, s[23:16]}, 32'd8);
    check("tx_overflow_set", {31'd0, s[4]}, 32'd1);
    check("tx_full", {31'd0, s[1]}, 32'd1);
    bus_write(4'hC, 32'h2);
    bus_read(4'h8, s);
    check("tx_count_flush", {24'd0, s[23:16]}, 32'd0);
    check("tx_empty_flush", {31'd0, s[2]}, 32'd1);
    bus_write(4'hC, 32'h4);
    bus_read(4'h8, s);
    check("tx_overflow_clr", {31'd0, s[4]}, 32'd0);
    busy_force = 1'b0;

    // loopback
    bus_write(4'hC, 32'h8);
    bus_read(4'hC, s);
    check("ctrl_loopback", s, 32'h8);
    sc = start_cnt;
    bus_write(4'h0, 32'h5A);
    bus_read(4'h8, s);
    check("lb_not_yet", {31'd0, s[0]}, 32'd0);
    rx_model.push_back(8'h5A);
    rx_read();
    check("lb_no_start", start_cnt, sc);
    bus_write(4'hC, 32'h0);

    // simultaneous pop and capture on a full RX FIFO
    for (int i = 0; i < 8; i++) drive_rx(8'($urandom));
    b = 8'($urandom);
    uart_rx_ready = 1'b1; uart_rx_data = b;
    sel = 1'b1; re = 1'b1; addr = 4'h4;
    @(posedge clk); #1;
    sel = 1'b0; re = 1'b0;
    check("sim_rx_clear", {31'd0, uart_rx_clear}, 32'd1);
    model_capture(b);
    uart_rx_ready = 1'b0;
    @(posedge clk); #1;
    bus_read(4'h8, s);
    check("sim_rx_count", {24'd0, s[15:8]}, 32'd8);
    check("sim_no_overrun", {31'd0, s[3]}, 32'd0);
    for (int i = 0; i < 8; i++) rx_read();

    // random mix
    repeat (30) begin
      case ($urandom_range(0, 2))
        0: begin
          repeat ($urandom_range(1, 5)) tx_send(8'($urandom));
          wait_tx_idle();
        end
        1: drive_rx(8'($urandom));
        default: rx_read();
      endcase
    end
    bus_read(4'h8, s);
    check("rand_rx_count", {24'd0, s[15:8]}, rx_model.size());
    check("rand_overrun", {31'd0, s[3]}, {31'd0, exp_ovr});
    check("rand_irq", {31'd0, irq}, {31'd0, (rx_model.size() != 0) || exp_ovr});
    check("tx_all_sent", tx_exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_fifo_periph.md
# uart_fifo_periph

Memory-mapped UART peripheral that replaces the loose single-word tx/rx/clear registers around the UART core. It provides parametrised TX and RX byte FIFOs, a status register and a loopback mode, and it sits between the memory controller's peripheral select and the existing UART core's tx_start/tx_data/rx_data/rx_data_ready/clear_rx handshake. The core can queue several bytes without polling each one, and received bytes are buffered instead of being overwritten.

## Interface
- DATA_WIDTH, 32, bus word width (≥24)
- TX_DEPTH, 8, TX FIFO entries; power of 2, 2..128
- RX_DEPTH, 8, RX FIFO entries; power of 2, 2..128
- ADDR_WIDTH, 4, byte-offset width; bits [1:0] ignored

- clk  in  1  single clock for the whole block; all state updates on rising edge
- reset  in  1  synchronous, active-low; sampled on clk rising edge
- sel  in  1  peripheral selected this cycle
- we  in  1  write strobe (qualified by sel)
- re  in  1  read strobe (qualified by sel); pops only on RXDATA
- addr  in  ADDR_WIDTH  register byte offset
- wdata  in  DATA_WIDTH  write data
- rdata  out  DATA_WIDTH  combinational read data, 0 when !sel
- uart_tx_start  out  1  one-cycle launch pulse to UART core
- uart_tx_data  out  8  byte being sent; held until next launch
- uart_tx_busy  in  1  UART transmitter busy
- uart_rx_data  in  8  received byte from UART core
- uart_rx_ready  in  1  UART has a byte (level)
- uart_rx_clear  out  1  one-cycle pulse acknowledging the received byte
- irq  out  1  registered: rx_count≠0 OR rx_overrun

## Operation
- Register map, selected by addr[ADDR_WIDTH-1:2]:
  - 0x0 TXDATA. Write pushes wdata[7:0]. Read returns 0.
  - 0x4 RXDATA. Read returns {0, head byte}. A read with re pops the head at the edge. When the FIFO is empty the read returns 0 and nothing pops.
  - 0x8 STATUS, read-only:
    - bit0 rx_not_empty, bit1 tx_full, bit2 tx_empty
    - bit3 rx_overrun (sticky), bit4 tx_overflow (sticky)
    - bit5 tx_idle (FSM in IDLE and TX FIFO empty), bit6 loopback
    - [15:8] rx_count, [23:16] tx_count
  - 0xC CTRL. Writes:
    - bit0 flush RX, bit1 flush TX, bit2 clear both sticky flags (all write-1, self-clearing pulses)
    - bit3 loopback (stored)
    - Reads return {0, loopback at bit3}.
- Writing TXDATA while the TX FIFO is full drops the byte and sets tx_overflow.
- TX FSM states:
  - IDLE: when the TX FIFO is non-empty and !uart_tx_busy, pop the head into uart_tx_data and go to LAUNCH. In loopback, pop and push the byte into RX instead; stay in IDLE, no uart strobes.
  - LAUNCH: uart_tx_start=1 for exactly this cycle, then go to ACK.
  - ACK: wait for uart_tx_busy=1, then go to DONE. After 4 cycles without busy, return to IDLE and treat the byte as sent.
  - DONE: wait for uart_tx_busy=0, then go to IDLE.
- RX FSM states (ignores uart_rx_ready while loopback=1):
  - R_IDLE: when uart_rx_ready=1, push uart_rx_data, or set rx_overrun and drop the byte if RX is full. Pulse uart_rx_clear and go to R_WAIT.
  - R_WAIT: wait for uart_rx_ready=0, then go to R_IDLE. This gives exactly one capture per byte.
- Loopback push into a full RX FIFO sets rx_overrun and drops the byte; the TX pop still occurs.
- FIFOs are circular, with pointer width log2(DEPTH) and count width log2(DEPTH)+1. Pointers wrap naturally.
- Simultaneous push and pop:
  - On a full FIFO: legal, count unchanged, both happen.
  - On an empty FIFO: pop is ignored, push happens.
  - RX push from the FSM and a pop from the bus in the same cycle are both honoured.
- Flush vs. push in the same cycle: flush wins and the FIFO ends empty. A TX flush does not abort a byte already in LAUNCH/ACK/DONE.
- Toggling loopback mid-transfer takes effect only when the TX FSM next evaluates in IDLE.

## Timing
- Reset (reset=0 at an edge) takes effect at that edge:
  - FIFOs empty, pointers 0
  - FSMs in IDLE/R_IDLE
  - sticky flags 0, loopback 0
  - uart_tx_start=0, uart_tx_data=0, uart_rx_clear=0, irq=0
- Reset mid-transfer abandons the transfer with no further strobes.
- Register writes and pops take effect at the edge. STATUS reflects them from the next cycle.
- TXDATA write to uart_tx_start, with the FSM idle and UART not busy: write edge, IDLE pop edge, start asserted in the following cycle. uart_tx_start rises 2 cycles after the write edge.
- uart_rx_ready rise to uart_rx_clear pulse: next cycle. The byte is readable via RXDATA 1 cycle after capture.
- irq is registered, 1 cycle behind the flags.
- Loopback byte: readable in RXDATA 2 cycles after the TXDATA write.

## Test plan
- Reset, then read STATUS. Expect 0x00000024 (tx_empty, tx_idle), irq=0, all uart outputs 0.
- Write 0x41, 0x42, 0x43 to TXDATA. The UART model asserts busy 1 cycle after start and holds it for 10 cycles. Expect three start pulses with tx_data 0x41, 0x42, 0x43 in order, never a start while busy, and tx_idle=1 at the end.
- Drive 9 rx bytes 0x10..0x18 (RX_DEPTH=8) without reading. Expect a clear pulse for each, rx_count=8, rx_overrun=1, irq=1. Reads return 0x10..0x17, then 0. CTRL write 0x4 sets overrun to 0.
- Write 9 TXDATA bytes while busy is held at 1. Expect tx_count=8 and tx_overflow=1. CTRL write 0x2 sets tx_count to 0 and tx_empty to 1.
- Loopback: CTRL=0x8, write 0x5A. Expect no uart_tx_start; RXDATA reads 0x5A 2 cycles after the write.
- Simultaneous RXDATA pop and uart_rx_ready capture with RX full: count stays 8, no overrun, and the FIFO order is preserved.
